// File: rtl/lc3b_types.sv
// Shared LC-3b type package: machine word, instruction-fetch FSM states and
// fetch-address helpers used by the instruction-fetch unit.
package lc3b_types;

  // 16-bit LC-3b machine word (data and byte address)
  typedef logic [15:0] lc3b_word;

  // Instruction-fetch FSM states
  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding, result will be kept
    DROP  = 2'd1,  // request outstanding, result will be discarded
    HOLD  = 2'd2   // fetched word presented to decode
  } if_state_t;

  // Size of one instruction in bytes
  localparam int unsigned LC3B_INSTR_BYTES = 2;

  // Sequential next instruction address, 16-bit modulo (0xFFFE wraps to 0x0000)
  function automatic lc3b_word pc_next(input lc3b_word addr);
    return addr + lc3b_word'(LC3B_INSTR_BYTES);
  endfunction

  // Force an address onto an instruction (even byte) boundary
  function automatic lc3b_word align_word(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_fetch_unit_sat_counter.sv
// 16-bit (by default) saturating enable counter. Counts enabled cycles, sticks
// at all-ones, and is cleared only by the asynchronous active-low reset.
module if_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Saturating count of enabled cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {W{1'b0}};
    end else if (en && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit for the pipelined LC-3b.
// Owns the PC, issues single-word reads to the I-side memory, holds the
// fetched word until decode accepts it, and flushes on execute redirects.
// An outstanding memory read is never abandoned by a redirect: it is allowed
// to complete (DROP state) and its data is discarded.
// Optional build macro: IF_PERF_CNT_EN adds the stall_cycles port, a
// saturating count of cycles with out_valid=1 and out_ready=0.
module if_fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  if_state_t state_r;
  if_state_t state_nxt_s;
  lc3b_word  pc_r;
  lc3b_word  pc_nxt_s;
  lc3b_word  req_addr_r;
  lc3b_word  req_addr_nxt_s;
  lc3b_word  instr_r;
  lc3b_word  instr_nxt_s;
  lc3b_word  instr_pc_r;
  lc3b_word  instr_pc_nxt_s;
  lc3b_word  redir_pc_s;
  lc3b_word  drop_base_s;
  logic      mem_read_s;
  logic      out_valid_s;

  // Redirect target aligned to an instruction boundary
  assign redir_pc_s  = align_word(redirect_pc);
  // Address to restart from when a dropped read completes (latest redirect wins)
  assign drop_base_s = redirect ? redir_pc_s : pc_r;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; redirect takes priority over decode acceptance
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH: begin
        if (redirect && mem_resp) begin
          state_nxt_s = FETCH;
        end else if (redirect) begin
          state_nxt_s = DROP;
        end else if (mem_resp) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DROP: begin
        if (mem_resp) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DROP;
        end
      end
      HOLD: begin
        if (redirect || out_ready) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = FETCH;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    mem_read_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      FETCH:   mem_read_s  = 1'b1;
      DROP:    mem_read_s  = 1'b1;
      HOLD:    out_valid_s = 1'b1;
      default: begin
        mem_read_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Next values of PC, request address and held instruction
  always_comb begin
    pc_nxt_s       = pc_r;
    req_addr_nxt_s = req_addr_r;
    instr_nxt_s    = instr_r;
    instr_pc_nxt_s = instr_pc_r;
    case (state_r)
      FETCH: begin
        if (redirect && mem_resp) begin
          req_addr_nxt_s = redir_pc_s;
          pc_nxt_s       = pc_next(redir_pc_s);
        end else if (redirect) begin
          pc_nxt_s       = redir_pc_s;
        end else if (mem_resp) begin
          instr_nxt_s    = mem_rdata;
          instr_pc_nxt_s = req_addr_r;
        end else begin
          pc_nxt_s       = pc_r;
        end
      end
      DROP: begin
        if (mem_resp) begin
          req_addr_nxt_s = drop_base_s;
          pc_nxt_s       = pc_next(drop_base_s);
        end else if (redirect) begin
          pc_nxt_s       = redir_pc_s;
        end else begin
          pc_nxt_s       = pc_r;
        end
      end
      HOLD: begin
        if (redirect) begin
          req_addr_nxt_s = redir_pc_s;
          pc_nxt_s       = pc_next(redir_pc_s);
        end else if (out_ready) begin
          req_addr_nxt_s = pc_r;
          pc_nxt_s       = pc_next(pc_r);
        end else begin
          pc_nxt_s       = pc_r;
        end
      end
      default: begin
        pc_nxt_s       = pc_r;
        req_addr_nxt_s = req_addr_r;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r       <= pc_next(RESET_PC);
      req_addr_r <= RESET_PC;
      instr_r    <= 16'h0000;
      instr_pc_r <= 16'h0000;
    end else begin
      pc_r       <= pc_nxt_s;
      req_addr_r <= req_addr_nxt_s;
      instr_r    <= instr_nxt_s;
      instr_pc_r <= instr_pc_nxt_s;
    end
  end

  assign mem_read    = mem_read_s;
  assign mem_address = req_addr_r;
  assign out_valid   = out_valid_s;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;

`ifdef IF_PERF_CNT_EN
  if_sat_counter #(
    .W (16)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (out_valid_s && !out_ready),
    .count   (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. Two instances share the
// clock: one with the default RESET_PC and one with RESET_PC=16'hFFFE.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_if_fetch_unit;

  logic        clk;
  int          n_tests;
  int          n_fail;

  // Default-reset-PC instance signals
  logic        reset_n;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;

  // RESET_PC = 16'hFFFE instance signals
  logic        w_reset_n;
  logic        w_mem_read;
  logic [15:0] w_mem_address;
  logic        w_mem_resp;
  logic [15:0] w_mem_rdata;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_instr;
  logic [15:0] w_instr_pc;
  logic        w_redirect;
  logic [15:0] w_redirect_pc;

`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] w_stall_cycles;
`endif

  if_fetch_unit #(.RESET_PC(16'h0000)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  if_fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk         (clk),
    .reset_n     (w_reset_n),
    .mem_read    (w_mem_read),
    .mem_address (w_mem_address),
    .mem_resp    (w_mem_resp),
    .mem_rdata   (w_mem_rdata),
    .out_valid   (w_out_valid),
    .out_ready   (w_out_ready),
    .instr       (w_instr),
    .instr_pc    (w_instr_pc),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles(w_stall_cycles)
`endif
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0; mem_resp = 1'b0; mem_rdata = 16'h0000; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000;
    w_reset_n = 1'b0; w_mem_resp = 1'b0; w_mem_rdata = 16'h0000; w_out_ready = 1'b0;
    w_redirect = 1'b0; w_redirect_pc = 16'h0000;
    tick();
    tick();

    // Reset state
    check("rst_mem_read",  {31'd0, mem_read},  32'd1);
    check("rst_mem_addr",  {16'd0, mem_address}, 32'h0000);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr",     {16'd0, instr},     32'h0000);
    check("rst_instr_pc",  {16'd0, instr_pc},  32'h0000);
`ifdef IF_PERF_CNT_EN
    check("rst_stall",     {16'd0, stall_cycles}, 32'd0);
`endif
    reset_n = 1'b1;

    // 1: response two cycles after the request, decode ready
    tick();
    tick();
    check("t1_addr_held", {16'd0, mem_address}, 32'h0000);
    mem_resp = 1'b1; mem_rdata = 16'h1234; out_ready = 1'b1;
    check("t1_no_valid_on_resp", {31'd0, out_valid}, 32'd0);
    tick();
    mem_resp = 1'b0;
    check("t1_valid",     {31'd0, out_valid}, 32'd1);
    check("t1_instr",     {16'd0, instr},     32'h1234);
    check("t1_instr_pc",  {16'd0, instr_pc},  32'h0000);
    check("t1_read_low",  {31'd0, mem_read},  32'd0);
    tick();
    check("t1_next_addr", {16'd0, mem_address}, 32'h0002);
    check("t1_next_read", {31'd0, mem_read},  32'd1);
    check("t1_valid_low", {31'd0, out_valid}, 32'd0);

    // 2: decode back-pressure for five cycles
    mem_resp = 1'b1; mem_rdata = 16'hABCD; out_ready = 1'b0;
    tick();
    mem_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_valid",    {31'd0, out_valid}, 32'd1);
      check("t2_instr",    {16'd0, instr},     32'hABCD);
      check("t2_instr_pc", {16'd0, instr_pc},  32'h0002);
      check("t2_no_read",  {31'd0, mem_read},  32'd0);
      tick();
    end
`ifdef IF_PERF_CNT_EN
    check("t2_stall_cnt", {16'd0, stall_cycles}, 32'd5);
`endif
    out_ready = 1'b1;
    tick();
    check("t2_next_addr", {16'd0, mem_address}, 32'h0004);
`ifdef IF_PERF_CNT_EN
    check("t2_stall_hold", {16'd0, stall_cycles}, 32'd5);
`endif

    // 3: redirect while the fetch to 0x0004 is outstanding
    redirect = 1'b1; redirect_pc = 16'h3001;
    tick();
    redirect = 1'b0;
    check("t3_addr_stable0", {16'd0, mem_address}, 32'h0004);
    check("t3_read_held",    {31'd0, mem_read},    32'd1);
    tick();
    check("t3_addr_stable1", {16'd0, mem_address}, 32'h0004);
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_resp = 1'b0;
    check("t3_dropped",   {31'd0, out_valid},  32'd0);
    check("t3_new_addr",  {16'd0, mem_address}, 32'h3000);
    check("t3_new_read",  {31'd0, mem_read},   32'd1);
    tick();
    check("t3_still_dropped", {31'd0, out_valid}, 32'd0);

    // 4: redirect coincident with the response in FETCH
    redirect = 1'b1; redirect_pc = 16'h5000; mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    redirect = 1'b0; mem_resp = 1'b0;
    check("t4_addr",  {16'd0, mem_address}, 32'h5000);
    check("t4_read",  {31'd0, mem_read},   32'd1);
    check("t4_valid", {31'd0, out_valid},  32'd0);
    mem_resp = 1'b1; mem_rdata = 16'h1111; out_ready = 1'b0;
    tick();
    mem_resp = 1'b0;
    check("t4_no_drop_valid", {31'd0, out_valid}, 32'd1);
    check("t4_instr",         {16'd0, instr},     32'h1111);
    check("t4_instr_pc",      {16'd0, instr_pc},  32'h5000);

    // 5: redirect while holding, decode ready the same cycle
    redirect = 1'b1; redirect_pc = 16'h7000; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("t5_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t5_addr",       {16'd0, mem_address}, 32'h7000);
    mem_resp = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_resp = 1'b0;
    check("t5_instr",    {16'd0, instr},    32'h2222);
    check("t5_instr_pc", {16'd0, instr_pc}, 32'h7000);
    tick();
    check("t5_seq_addr", {16'd0, mem_address}, 32'h7002);

    // 6: RESET_PC = 0xFFFE wraps, then asynchronous reset mid-fetch
    w_reset_n = 1'b1;
    tick();
    check("t6_first_addr", {16'd0, w_mem_address}, 32'hFFFE);
    check("t6_first_read", {31'd0, w_mem_read},    32'd1);
    w_mem_resp = 1'b1; w_mem_rdata = 16'h3333; w_out_ready = 1'b1;
    tick();
    w_mem_resp = 1'b0;
    check("t6_instr_pc", {16'd0, w_instr_pc}, 32'hFFFE);
    tick();
    check("t6_wrap_addr", {16'd0, w_mem_address}, 32'h0000);
    #2;
    w_reset_n = 1'b0;
    #1;
    check("t6_async_addr", {16'd0, w_mem_address}, 32'hFFFE);
    check("t6_async_read", {31'd0, w_mem_read},    32'd1);
    check("t6_async_valid", {31'd0, w_out_valid},  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
